// File: rtl/core_pkg.sv
// Shared core types and constants used by the front-end stages.
// Holds the fetch FSM states, the buffer entry layout and opcode fields.
package core_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned OP_LSB = 0;
   localparam int unsigned OP_MSB = 6;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic {
      RUN,
      FAULT
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between imem responses and decode.
// Flush wins over a same-cycle push; push and pop together work when full.
module fetch_fifo import core_pkg::*; #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  fetch_entry_t           wdata_i,
   output fetch_entry_t           rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign do_push = push_i & ~flush_i;
   assign do_pop  = pop_i & ~empty_o;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= wdata_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + AW'(1);
         end
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Fetch credit must make a push into a full buffer impossible.
   always_ff @(posedge clk) begin
      if (rst_n && do_push) begin
         assert (!full_o || do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues imem requests,
// buffers responses and hands them to decode; redirects flush wrong path.
module fetch_unit import core_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [6:0]  instr_op,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc_plus4,
   output logic        fetch_fault
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   typedef logic [CW-1:0] cnt_t;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [XLEN-1:0] redir_pc_q, redir_pc_d;
   cnt_t            out_q, out_d;
   cnt_t            discard_q, discard_d;
   logic            hold_q, hold_d;
   logic            redir_pend_q, redir_pend_d;
   logic            en_q;

   logic            gnt_fire;
   logic            redir_ok;
   logic            redir_bad;
   logic            credit;
   logic            push;
   logic            pop;
   logic            flush;
   logic            fifo_full;
   logic            fifo_empty;
   cnt_t            fifo_count;
   fetch_entry_t    head;
   fetch_entry_t    wentry;

   assign credit = en_q & ~fifo_full
                 & (({1'b0, out_q} + {1'b0, fifo_count})
                    < (CW+1)'(FIFO_DEPTH));

   // A pending request is never withdrawn; fresh ones wait out a redirect.
   assign imem_req  = hold_q
                    | (credit & (state_q == RUN) & ~redirect_valid);
   assign imem_addr = fetch_pc_q;
   assign gnt_fire  = imem_req & imem_gnt;

   assign redir_ok  = (state_q == RUN) & redirect_valid
                    & (redirect_pc[1:0] == 2'b00);
   assign redir_bad = (state_q == RUN) & redirect_valid
                    & (redirect_pc[1:0] != 2'b00);

   assign wentry = '{instr: imem_rdata, pc: rsp_pc_q};

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      rsp_pc_d     = rsp_pc_q;
      redir_pc_d   = redir_pc_q;
      redir_pend_d = redir_pend_q;
      discard_d    = discard_q;
      hold_d       = imem_req & ~imem_gnt;
      out_d        = out_q + cnt_t'(gnt_fire) - cnt_t'(imem_rvalid);
      push         = 1'b0;
      flush        = 1'b0;
      unique case (state_q)
         RUN: begin
            if (imem_rvalid) begin
               if (discard_q != '0) begin
                  discard_d = discard_q - cnt_t'(1);
               end else begin
                  push     = 1'b1;
                  rsp_pc_d = rsp_pc_q + 32'd4;
               end
            end
            if (gnt_fire) begin
               if (redir_pend_q) begin
                  fetch_pc_d   = redir_pc_q;
                  discard_d    = discard_d + cnt_t'(1);
                  redir_pend_d = 1'b0;
               end else begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end
            if (redir_ok) begin
               flush     = 1'b1;
               push      = 1'b0;
               discard_d = out_d;
               rsp_pc_d  = redirect_pc;
               if (hold_q && !imem_gnt) begin
                  redir_pend_d = 1'b1;
                  redir_pc_d   = redirect_pc;
               end else begin
                  redir_pend_d = 1'b0;
                  fetch_pc_d   = redirect_pc;
               end
            end else if (redir_bad) begin
               state_d = FAULT;
               flush   = 1'b1;
               push    = 1'b0;
            end
         end
         FAULT: begin
            flush = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         fetch_pc_q   <= RESET_PC;
         rsp_pc_q     <= RESET_PC;
         redir_pc_q   <= '0;
         redir_pend_q <= 1'b0;
         out_q        <= '0;
         discard_q    <= '0;
         hold_q       <= 1'b0;
         en_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         rsp_pc_q     <= rsp_pc_d;
         redir_pc_q   <= redir_pc_d;
         redir_pend_q <= redir_pend_d;
         out_q        <= out_d;
         discard_q    <= discard_d;
         hold_q       <= hold_d;
         en_q         <= 1'b1;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (wentry),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign instr_valid    = ~fifo_empty & (state_q == RUN);
   assign pop            = instr_valid & instr_ready;
   assign instr          = instr_valid ? head.instr : '0;
   assign instr_pc       = instr_valid ? head.pc : '0;
   assign instr_pc_plus4 = instr_valid ? head.pc + 32'd4 : '0;
   assign instr_op       = instr[OP_MSB:OP_LSB];
   assign fetch_fault    = state_q == FAULT;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem responder plus a queue-based
// model of fetch order, wrong-path epochs and the decode buffer.
module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [6:0]  instr_op;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;
   logic        fetch_fault;

   fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_op       (instr_op),
      .instr_pc       (instr_pc),
      .instr_pc_plus4 (instr_pc_plus4),
      .fetch_fault    (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ep;
      int          due;
   } fl_t;

   typedef struct {
      logic [31:0] w;
      logic [31:0] pc;
   } fe_t;

   fl_t         infl[$];
   fe_t         mfifo[$];
   int          epoch;
   logic [31:0] ref_pc;
   bit          mfault;
   bit          hold;
   logic [31:0] hold_addr;
   int          hold_ep;
   bit          first;
   int          cyc;
   int          last_due;
   int          gnt_pct;
   int          lat_min;
   int          lat_max;
   int          nchk;
   int          nfail;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive memory, check outputs, advance the model.
   task automatic cycle();
      fl_t  e;
      fl_t  rv;
      bit   have_rv;
      int   d;
      logic exp_req;
      imem_gnt = ($urandom_range(99) < gnt_pct);
      if (infl.size() > 0 && infl[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(infl[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
      chk("fault", fetch_fault, mfault);
      chk("valid", instr_valid, mfifo.size() != 0);
      if (mfifo.size() != 0) begin
         chk("instr", instr, mfifo[0].w);
         chk("pc", instr_pc, mfifo[0].pc);
         chk("pc4", instr_pc_plus4, mfifo[0].pc + 32'd4);
         chk("op", instr_op, mfifo[0].w & 32'h7F);
      end
      exp_req = hold || (!mfault && !redirect_valid
                && (infl.size() + mfifo.size() < DEPTH));
      if (!first) chk("req", imem_req, exp_req);
      if (imem_req) chk("addr", imem_addr, hold ? hold_addr : ref_pc);
      if (instr_valid && instr_ready && mfifo.size() != 0)
         mfifo.delete(0);
      have_rv = 0;
      if (imem_rvalid) begin
         rv      = infl.pop_front();
         have_rv = 1;
      end
      if (imem_req && imem_gnt) begin
         e.ep   = hold ? hold_ep : epoch;
         e.addr = hold ? hold_addr : ref_pc;
         d = cyc + $urandom_range(lat_max, lat_min);
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         e.due    = d;
         infl.push_back(e);
         if (e.ep == epoch) ref_pc += 32'd4;
         hold = 0;
      end else if (imem_req && !hold) begin
         hold      = 1;
         hold_addr = ref_pc;
         hold_ep   = epoch;
      end
      if (redirect_valid && !mfault) begin
         epoch++;
         mfifo.delete();
         if (redirect_pc[1:0] == 2'b00) ref_pc = redirect_pc;
         else mfault = 1;
      end
      if (have_rv && rv.ep == epoch && !mfault)
         mfifo.push_back('{mem_word(rv.addr), rv.addr});
      first = 0;
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      infl.delete();
      mfifo.delete();
      epoch    = 0;
      ref_pc   = 32'h0;
      mfault   = 0;
      hold     = 0;
      first    = 1;
      cyc      = 0;
      last_due = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(string tag);
      int n;
      n = 0;
      while (!instr_valid && n < 50) begin
         cycle();
         n++;
      end
      chk(tag, instr_valid, 1'b1);
   endtask

   task automatic redirect(logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      cycle();
      redirect_valid = 1'b0;
   endtask

   initial begin
      int          n;
      logic [31:0] saved;
      nchk    = 0;
      nfail   = 0;
      gnt_pct = 100;
      lat_min = 1;
      lat_max = 1;
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      repeat (2) @(negedge clk);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_fault", fetch_fault, 1'b0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_pc4", instr_pc_plus4, 32'h0);

      // Decode stalled: buffer fills, requests stop, head holds.
      do_reset();
      repeat (10) cycle();
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_pc", instr_pc, 32'h0);
      chk("stall_op", instr_op, 7'h13);
      chk("stall_req", imem_req, 1'b0);

      // Drain and stream with 1-cycle latency.
      instr_ready = 1'b1;
      repeat (20) cycle();

      // Redirect with two late responses in flight.
      lat_min = 3;
      lat_max = 3;
      n = 0;
      while (infl.size() < 2 && n < 20) begin
         cycle();
         n++;
      end
      chk("two_inflight", infl.size(), 2);
      redirect(32'h0000_0100);
      wait_valid("wait_100");
      chk("pc_100", instr_pc, 32'h100);
      cycle();
      wait_valid("wait_104");
      chk("pc_104", instr_pc, 32'h104);

      // Grant withheld across a redirect.
      lat_min = 1;
      lat_max = 1;
      gnt_pct = 0;
      n = 0;
      while (!hold && n < 20) begin
         cycle();
         n++;
      end
      chk("held_req", imem_req, 1'b1);
      saved = hold_addr;
      redirect(32'h0000_0200);
      cycle();
      cycle();
      chk("held_addr", imem_addr, saved);
      gnt_pct = 100;
      wait_valid("wait_200");
      chk("pc_200", instr_pc, 32'h200);

      // PC wrap at 2^32.
      redirect(32'hFFFF_FFF8);
      wait_valid("wait_wrap0");
      chk("pc_fff8", instr_pc, 32'hFFFF_FFF8);
      cycle();
      wait_valid("wait_wrap1");
      chk("pc4_wrap", instr_pc_plus4, 32'h0);
      cycle();
      wait_valid("wait_wrap2");
      chk("pc_wrapped", instr_pc, 32'h0);

      // Randomised traffic with aligned redirects.
      gnt_pct = 70;
      lat_max = 3;
      for (int i = 0; i < 400; i++) begin
         instr_ready    = $urandom_range(3) != 0;
         redirect_valid = $urandom_range(19) == 0;
         redirect_pc    = $urandom & 32'hFFFF_FFFC;
         cycle();
      end
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;

      // Misaligned redirect: sticky fault, no further fetches.
      redirect(32'h0000_0102);
      chk("fault_set", fetch_fault, 1'b1);
      chk("fault_valid", instr_valid, 1'b0);
      repeat (12) cycle();
      chk("fault_req", imem_req, 1'b0);
      chk("fault_stick", fetch_fault, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("fault_clr", fetch_fault, 1'b0);

      // Async reset with the buffer full.
      do_reset();
      gnt_pct = 100;
      lat_max = 1;
      n = 0;
      while (mfifo.size() < DEPTH && n < 20) begin
         cycle();
         n++;
      end
      chk("full_valid", instr_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", instr_valid, 1'b0);
      chk("arst_req", imem_req, 1'b0);
      chk("arst_fault", fetch_fault, 1'b0);
      chk("arst_pc", instr_pc, 32'h0);
      do_reset();
      instr_ready = 1'b1;
      n = 0;
      while (!imem_req && n < 5) begin
         cycle();
         n++;
      end
      chk("boot_req", imem_req, 1'b1);
      chk("boot_addr", imem_addr, 32'h0);
      repeat (10) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main decoder.
- Owns the architectural fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents instr/instr_pc/instr_pc_plus4/instr_op to decode under a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries and also the max outstanding-plus-buffered credit (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address, bits[1:0]=0
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid (in order, >=1 cycle after gnt)
imem_rdata  input  32  response instruction word
redirect_valid  input  1  taken branch/jal/jalr from execute
redirect_pc  input  32  new fetch target
instr_valid  output  1  instruction available to decode
instr_ready  input  1  decode accepts instruction
instr  output  32  instruction word (FIFO head)
instr_op  output  7  instr[6:0], feeds decoder op
instr_pc  output  32  PC of instr
instr_pc_plus4  output  32  instr_pc + 4, modulo 2^32
fetch_fault  output  1  sticky misaligned-redirect fault

Behaviour:
- Reset (async assert, sync release) values:
  - fetch_pc=RESET_PC; FIFO empty.
  - outstanding=0, discard=0, state=RUN.
  - imem_req=0, instr_valid=0, fetch_fault=0.
  - instr/instr_pc/instr_pc_plus4 = 0.
- States: RUN, FAULT.
- RUN, request issue:
  - imem_req=1 when outstanding + fifo_count < FIFO_DEPTH, or a request is already pending.
  - imem_addr=fetch_pc.
- Request hold rule: once imem_req=1, req and addr stay stable until imem_gnt=1. No withdrawal, even on redirect.
- On gnt: fetch_pc += 4 (wrap at 2^32); outstanding++. Each entry stores its PC.
- On rvalid:
  - If discard>0: drop the word, discard--.
  - Else: push {rdata, pc} into the FIFO.
  - In both cases outstanding--.
- Credit rule: the FIFO cannot overflow. An rvalid arriving with the FIFO full is impossible by construction; assert it in simulation.
- Output timing:
  - instr_valid = FIFO non-empty. Registered storage, so rvalid at cycle N gives instr_valid at N+1.
  - Pop on instr_valid & instr_ready.
  - With instr_ready=0, outputs are held stable.
- Redirect with redirect_pc[1:0]==0:
  - fetch_pc = redirect_pc for the next request.
  - FIFO flushed.
  - discard = outstanding, adjusted for same-cycle gnt and rvalid events.
  - A pending un-granted request completes its handshake; it is then counted into discard.
  - A transfer on instr_valid&instr_ready in the redirect cycle completes.
  - An rvalid in the redirect cycle is dropped.
  - The new-target request is asserted the cycle after redirect, if credit allows.
- Redirect with redirect_pc[1:0]!=0: enter FAULT.
  - fetch_fault=1 (sticky until reset).
  - FIFO flushed; instr_valid=0; no new requests.
  - A pending request finishes its handshake; late responses are discarded.
- Simultaneous gnt+rvalid: outstanding unchanged.
- Simultaneous push+pop: count unchanged; works with the FIFO full.
- Reset mid-transaction: all state cleared immediately. Stale responses after reset are not guarded (the memory is reset with the core).

Decomposition:
- Shared package core_pkg:
  - fetch_state_t enum {RUN, FAULT}.
  - XLEN=32.
  - Opcode field slice constants (OP_LSB=0, OP_MSB=6), alongside the existing opcode defines.
- Sub-module fetch_fifo: parameterised FIFO_DEPTH, entry {instr[31:0], pc[31:0]}.
  - Ports: push, pop, flush, full, empty, count.
  - Same-cycle flush overrides push.
- Counters and FSM stay in fetch_unit.

Test Plan:
1. Reset release, imem always gnt with 1-cycle rvalid, instr_ready=1 -> imem_addr 0x0,0x4,0x8…; instr_pc sequence 0x0,0x4,0x8; instr_pc_plus4=instr_pc+4; instr_op=rdata[6:0] (e.g. 0x00500093 -> op 0x13).
2. instr_ready=0 for 10 cycles -> at most 2 words buffered; imem_req drops; outputs hold first word at PC 0x0; releasing ready drains 0x0,0x4 in order.
3. Redirect to 0x100 while 2 responses outstanding (rvalid latency 3) -> both late words dropped; next instr_pc 0x100, then 0x104.
4. gnt withheld 4 cycles, redirect to 0x200 in cycle 2 -> imem_addr stays at the old address until gnt; that response is discarded; next request addr 0x200.
5. Redirect to 0x102 -> fetch_fault=1 the next cycle; instr_valid=0; imem_req=0 thereafter until rst_n asserted.
6. Reset asserted mid-stream with the FIFO full -> instr_valid, imem_req, fetch_fault drop to 0 asynchronously; after release the first imem_addr is RESET_PC.
